// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the sequential ALU.
//   - op_t / OP_*   : 4-bit operation codes presented on the op bus
//   - state_t / S_* : FSM state encoding, also visible on dbg_state_o
package alu_seq_pkg;

  typedef logic [3:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_ADC   = 4'd2;
  localparam op_t OP_SBC   = 4'd3;
  localparam op_t OP_AND   = 4'd4;
  localparam op_t OP_OR    = 4'd5;
  localparam op_t OP_XOR   = 4'd6;
  localparam op_t OP_NOTA  = 4'd7;
  localparam op_t OP_PASSA = 4'd8;
  localparam op_t OP_PASSB = 4'd9;
  localparam op_t OP_SHL   = 4'd10;
  localparam op_t OP_SHR   = 4'd11;
  localparam op_t OP_SAR   = 4'd12;
  localparam op_t OP_MUL   = 4'd13;
  localparam op_t OP_CLC   = 4'd14;
  localparam op_t OP_NOP   = 4'd15;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bus of the sequential ALU.
//   Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high. A producer holds its payload stable while valid is high
//   and ready is low; valid never depends on ready.
//   Input side : in_valid, in_ready, op, a, b
//   Output side: out_valid, out_ready, z, z_hi, flag_c/z/n/v
//   master = operand producer / result consumer, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] z_hi;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, z, z_hi, flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, z, z_hi, flag_c, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/alu_mul_step.sv
// alu_mul_step: one iteration of an unsigned shift-add multiplier.
//   acc_i   : running high half of the product
//   mplr_i  : multiplier; its low bits are consumed, product low bits enter at top
//   mcand_i : multiplicand (constant over the whole multiply)
//   acc_o / mplr_o : values after this step
// After WIDTH steps starting from acc=0, {acc, mplr} holds mcand * multiplier.
module alu_mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mplr_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mplr_o
);

  logic [WIDTH:0] sum;

  assign sum    = {1'b0, acc_i} + (mplr_i[0] ? {1'b0, mcand_i} : '0);
  // Shift the (WIDTH+1)-bit sum and the multiplier right as one register.
  assign acc_o  = sum[WIDTH:1];
  assign mplr_o = {sum[0], mplr_i[WIDTH-1:1]};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, sticky carry and a
// multi-cycle shift-add multiplier.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : alu_seq_if slave (operands in, result + flags out)
//   dbg_state_o : current FSM state (S_IDLE / S_BUSY / S_DONE)
// Non-MUL ops are computed from the live inputs and registered at the accept
// edge; MUL captures its operands and steps WIDTH cycles in S_BUSY.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d, z_hi_q, z_hi_d;
  logic             c_q, c_d, fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;
  logic [WIDTH-1:0] acc_q, acc_d, mplr_q, mplr_d, mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             is_sub;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shl_w, shr_w, sar_w;
  logic [WIDTH-1:0] res_z;
  logic             res_c, res_v;
  logic [WIDTH-1:0] step_acc, step_mplr;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  // Adder: subtraction adds the inverted operand; the carry-in selects
  // plain, two's-complement or sticky-carry chaining.
  assign is_sub = (bus.op == OP_SUB) || (bus.op == OP_SBC);
  assign b_eff  = is_sub ? ~bus.b : bus.b;

  always_comb begin
    cin = 1'b0;
    case (bus.op)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = c_q;
      default:        cin = 1'b0;
    endcase
  end

  assign sum = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  // Shifters carry one extra bit so the last bit shifted out lands in a
  // fixed position: bit WIDTH for left shifts, bit 0 for right shifts.
  assign shamt = bus.b[SHW-1:0];
  assign shl_w = {1'b0, bus.a} << shamt;
  assign shr_w = {bus.a, 1'b0} >> shamt;
  assign sar_w = $unsigned($signed({bus.a, 1'b0}) >>> shamt);

  always_comb begin
    res_z = '0;
    res_c = c_q;
    res_v = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        res_z = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:   res_z = bus.a & bus.b;
      OP_OR:    res_z = bus.a | bus.b;
      OP_XOR:   res_z = bus.a ^ bus.b;
      OP_NOTA:  res_z = ~bus.a;
      OP_PASSA: res_z = bus.a;
      OP_PASSB: res_z = bus.b;
      OP_SHL: begin
        res_z = shl_w[WIDTH-1:0];
        if (shamt != '0) res_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_z = shr_w[WIDTH:1];
        if (shamt != '0) res_c = shr_w[0];
      end
      OP_SAR: begin
        res_z = sar_w[WIDTH:1];
        if (shamt != '0) res_c = sar_w[0];
      end
      default: res_z = '0;
    endcase
  end

  alu_mul_step #(.WIDTH(WIDTH)) u_mul_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mplr_o  (step_mplr)
  );

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    z_hi_d  = z_hi_q;
    c_d     = c_q;
    fz_d    = fz_q;
    fn_d    = fn_q;
    fv_d    = fv_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            acc_d   = '0;
            mplr_d  = bus.b;
            mcand_d = bus.a;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            case (bus.op)
              OP_NOP: ;
              OP_CLC: c_d = 1'b0;
              default: begin
                z_d    = res_z;
                z_hi_d = '0;
                c_d    = res_c;
                fz_d   = (res_z == '0);
                fn_d   = res_z[WIDTH-1];
                fv_d   = res_v;
              end
            endcase
          end
        end
      end
      S_BUSY: begin
        acc_d  = step_acc;
        mplr_d = step_mplr;
        cnt_d  = cnt_q + 1'b1;
        // Last step: the step outputs already hold the full product.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          z_d     = step_mplr;
          z_hi_d  = step_acc;
          c_d     = |step_acc;
          fz_d    = (step_mplr == '0);
          fn_d    = step_mplr[WIDTH-1];
          fv_d    = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      z_hi_q  <= '0;
      c_q     <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
      fv_q    <= 1'b0;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      z_hi_q  <= z_hi_d;
      c_q     <= c_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
      fv_q    <= fv_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.z         = z_q;
  assign bus.z_hi      = z_hi_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_z    = fz_q;
  assign bus.flag_n    = fn_q;
  assign bus.flag_v    = fv_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Takes operands through a valid/ready handshake and holds the result until the consumer accepts it.
- Keeps a sticky carry flag so ADC chains across operations; adds signed flags, barrel shifts, and a multi-cycle shift-add multiplier.
- Sits between the register file read ports and the writeback mux of the CPU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).
- SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are presented
- in_ready  output  1  block can accept an operation
- op  input  4  operation code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0] for shifts)
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- z  output  WIDTH  result (low half for MUL)
- z_hi  output  WIDTH  MUL high half; 0 for all other ops
- flag_c  output  1  carry flag (sticky)
- flag_z  output  1  z == 0
- flag_n  output  1  z[WIDTH-1]
- flag_v  output  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE; z, z_hi, flag_c/z/n/v all 0; out_valid=0; in_ready=1 once rst_n deasserts.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE).
- Accept = in_valid && in_ready. Operands and op are captured on accept; input changes afterwards have no effect.
- Transitions from IDLE:
  - Accepted non-MUL op: result registered at the accepting edge; next cycle DONE with out_valid=1 (latency 1).
  - Accepted MUL: BUSY for exactly WIDTH cycles (one shift-add step per cycle), then DONE. Latency WIDTH+1 from the accept edge to out_valid.
- DONE: out_valid=1 and outputs held stable; on out_ready go to IDLE. in_ready is low during DONE, so there is no overlap; the next accept is possible the cycle after the handshake.
- Opcodes: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOTA, 8 PASSA, 9 PASSB, 10 SHL, 11 SHR (logical), 12 SAR (arithmetic), 13 MUL (unsigned), 14 CLC, 15 NOP.
- Arithmetic, with a (WIDTH+1)-bit sum:
  - ADD: a+b+0.
  - SUB: a+~b+1.
  - ADC: a+b+flag_c.
  - SBC: a+~b+flag_c.
  - flag_c = sum[WIDTH]. For SUB/SBC, flag_c=1 means no borrow.
  - flag_v = (a_msb == b'_msb) && (z_msb != a_msb), where b' is the operand actually added.
- Logic ops (AND/OR/XOR/NOTA/PASSA/PASSB): flag_c unchanged; flag_v=0.
- Shifts: amount = b[SHW-1:0]. flag_c = last bit shifted out; amount 0 gives z=a and leaves flag_c unchanged. flag_v=0.
- MUL: {z_hi,z} = a*b; flag_c = |z_hi; flag_v=0.
- CLC: flag_c=0; z, z_hi, flag_z, flag_n, flag_v unchanged; completes in 1 cycle.
- NOP: completes in 1 cycle; no register changes.
- flag_z and flag_n are recomputed from z on every op except CLC and NOP.
- Reset mid-MUL or mid-DONE: abort immediately to reset values; the pending result is lost and flag_c is cleared.
- in_valid held high in DONE has no effect until IDLE.

Decomposition:
- Package alu_seq_pkg: op code localparams (OP_ADD..OP_NOP) and state encoding (S_IDLE, S_BUSY, S_DONE).
- Sub-module alu_mul_step: one shift-add multiplier iteration (accumulator, multiplier, multiplicand in; updated values out), instantiated once and stepped by the BUSY counter.
- Adder and logic unit stay inline in alu_seq.

Test Plan:
- WIDTH=8. Reset, then ADD a=0x7F b=0x01 -> one cycle later out_valid=1, z=0x80, flag_n=1, flag_v=1, flag_c=0, flag_z=0.
- ADD 0xFF+0x01 -> z=0x00, flag_c=1, flag_z=1. Then ADC 0x00+0x00 -> z=0x01 (sticky carry used). Then CLC followed by ADC 0x00+0x00 -> z=0x00.
- SUB 0x05-0x07 -> z=0xFE, flag_c=0 (borrow), flag_n=1. SUB 0x07-0x05 -> z=0x02, flag_c=1.
- MUL 0xFF*0xFF -> in_ready low for 8 BUSY cycles; out_valid on cycle 9 after accept with z=0x01, z_hi=0xFE, flag_c=1. A new in_valid during BUSY is not accepted.
- SHL a=0x81 b=1 -> z=0x02, flag_c=1. SAR a=0x80 b=3 -> z=0xF0, flag_c=0. SHR with amount 0 -> z=a, flag_c unchanged.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Assert rst_n=0 mid-MUL -> all outputs 0 and in_ready=1 after release.
